reg_bank_read_port: RTL and testbench

- General-purpose register bank of 8 x 16-bit entries with one write port and one handshaked read port.
- The write port is the MOV-style destination update: one write per clock when enabled.
- The read port is the other end of the transfer. It accepts read requests with valid/ready and returns data with a tag through a 2-entry response buffer.
- Sits between the instruction decode/operand-fetch stage and the ALU operand inputs.

---
 rtl/reg_bank_pkg.sv | 19 +
 rtl/reg_bank_read_port_if.sv | 32 +++
 rtl/rsp_fifo.sv | 71 +++++++
 rtl/reg_bank_read_port.sv | 64 ++++++
 tb/tb_reg_bank_read_port.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// Shared widths, types and response-entry layout for the register bank read port.
// Types only; no latency or backpressure of its own.
package reg_bank_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 3;
    localparam int RSP_DEPTH = 2;
    localparam int CNT_W     = $clog2(RSP_DEPTH) + 1;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]  rsp_cnt_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } rsp_entry_t;

endpackage

// File: rtl/reg_bank_read_port_if.sv
// Write port plus handshaked read request/response bus for the register bank.
// Master is the operand-fetch side; slave is the bank.
interface reg_bank_read_port_if;
    import reg_bank_pkg::*;

    logic      wr_en;
    reg_addr_t wr_addr;
    reg_data_t wr_data;

    logic      rd_req_valid;
    logic      rd_req_ready;
    reg_addr_t rd_req_addr;

    logic      rd_rsp_valid;
    logic      rd_rsp_ready;
    reg_data_t rd_rsp_data;
    reg_addr_t rd_rsp_addr;
    rsp_cnt_t  rsp_count;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_req_valid, rd_req_addr, rd_rsp_ready,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_addr, rsp_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_req_valid, rd_req_addr, rd_rsp_ready,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_addr, rsp_count
    );

endinterface

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO; push visible at head the cycle after the edge.
// Pushes when full and pops when empty are dropped; head holds last popped entry when empty.
module rsp_fifo
    import reg_bank_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  rsp_entry_t             push_dat_i,
    input  logic                   pop_i,
    output rsp_entry_t             head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    rsp_entry_t    mem_q [DEPTH];
    rsp_entry_t    last_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign count_o = count_q;

    // Once drained, keep presenting the entry that left last rather than a stale slot.
    assign head_o = empty_o ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reg_bank_read_port.sv
// 8x16 register bank, one write port, one read port returning tagged data via a 2-entry buffer.
// Response valid the cycle after acceptance; request ready only while the buffer has room.
module reg_bank_read_port
    import reg_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    reg_bank_read_port_if.slave  bus
);

    localparam int NREGS = 2**ADDR_W;

    reg_data_t  bank_q [NREGS];
    rsp_entry_t push_entry;
    rsp_entry_t head;
    logic       full;
    logic       empty;
    logic       acc;
    logic       pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            bank_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Ready comes only from registered occupancy: a full buffer refuses even when popping.
    assign bus.rd_req_ready = ~full;
    assign acc              = bus.rd_req_valid & ~full;
    assign pop              = ~empty & bus.rd_rsp_ready;

    always_comb begin
        push_entry      = '0;
        push_entry.addr = bus.rd_req_addr;
        if (bus.wr_en && (bus.wr_addr == bus.rd_req_addr)) begin
            push_entry.data = bus.wr_data;
        end else begin
            push_entry.data = bank_q[bus.rd_req_addr];
        end
    end

    rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (acc),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (bus.rsp_count)
    );

    assign bus.rd_rsp_valid = ~empty;
    assign bus.rd_rsp_data  = head.data;
    assign bus.rd_rsp_addr  = head.addr;

endmodule

// File: tb/tb_reg_bank_read_port.sv
// Directed and random stimulus for reg_bank_read_port against a queue-based reference model.
module tb_reg_bank_read_port;
    import reg_bank_pkg::*;

    logic clk;
    logic rst;

    reg_bank_read_port_if bus ();

    reg_bank_read_port dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_bank [8];
    logic [15:0] q_dat [$];
    logic [2:0]  q_adr [$];
    logic [15:0] m_last_dat;
    logic [2:0]  m_last_adr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_bank[i] = 16'h0;
        q_dat.delete();
        q_adr.delete();
        m_last_dat = 16'h0;
        m_last_adr = 3'h0;
    endtask

    task automatic check_outputs();
        logic        ev;
        logic [15:0] ed;
        logic [2:0]  ea;
        ev = (q_dat.size() != 0);
        ed = ev ? q_dat[0] : m_last_dat;
        ea = ev ? q_adr[0] : m_last_adr;
        check("rsp_valid", 32'(bus.rd_rsp_valid), 32'(ev));
        check("rsp_data",  32'(bus.rd_rsp_data),  32'(ed));
        check("rsp_addr",  32'(bus.rd_rsp_addr),  32'(ea));
        check("rsp_count", 32'(bus.rsp_count),    32'(q_dat.size()));
        check("req_ready", 32'(bus.rd_req_ready), 32'(q_dat.size() < 2));
    endtask

    task automatic drive_idle();
        bus.wr_en        = 1'b0;
        bus.wr_addr      = 3'h0;
        bus.wr_data      = 16'h0;
        bus.rd_req_valid = 1'b0;
        bus.rd_req_addr  = 3'h0;
        bus.rd_rsp_ready = 1'b0;
    endtask

    // One clock: drive at negedge, compare outputs, then advance the model at the edge.
    task automatic step(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic rv, input logic [2:0] ra, input logic rr);
        logic        acc;
        logic        pop;
        logic [15:0] d;
        @(negedge clk);
        bus.wr_en        = we;
        bus.wr_addr      = wa;
        bus.wr_data      = wd;
        bus.rd_req_valid = rv;
        bus.rd_req_addr  = ra;
        bus.rd_rsp_ready = rr;
        #1;
        check_outputs();
        acc = rv && (q_dat.size() < 2);
        pop = (q_dat.size() > 0) && rr;
        d   = (we && wa == ra) ? wd : m_bank[ra];
        @(posedge clk);
        if (pop) begin
            m_last_dat = q_dat.pop_front();
            m_last_adr = q_adr.pop_front();
        end
        if (acc) begin
            q_dat.push_back(d);
            q_adr.push_back(ra);
        end
        if (we) m_bank[wa] = wd;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset valid", 32'(bus.rd_rsp_valid), 32'h0);
        check("reset count", 32'(bus.rsp_count),    32'h0);
        check("reset ready", 32'(bus.rd_req_ready), 32'h1);
        check("reset data",  32'(bus.rd_rsp_data),  32'h0);
        check("reset addr",  32'(bus.rd_rsp_addr),  32'h0);

        // Basic read, then an untouched register
        step(1'b1, 3'd3, 16'h000A, 1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 16'h0,    1'b1, 3'd3, 1'b1);
        check("basic valid", 32'(bus.rd_rsp_valid), 32'h1);
        check("basic data",  32'(bus.rd_rsp_data),  32'h000A);
        check("basic addr",  32'(bus.rd_rsp_addr),  32'h3);
        step(1'b0, 3'd0, 16'h0,    1'b1, 3'd5, 1'b1);
        check("r5 data", 32'(bus.rd_rsp_data), 32'h0);
        check("r5 addr", 32'(bus.rd_rsp_addr), 32'h5);
        step(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 1'b1);

        // Write-first bypass
        step(1'b1, 3'd2, 16'hF00C, 1'b1, 3'd2, 1'b1);
        check("bypass data", 32'(bus.rd_rsp_data), 32'hF00C);
        step(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 1'b1);

        // Backpressure with a full buffer
        step(1'b1, 3'd1, 16'h1111, 1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 16'h0,    1'b1, 3'd1, 1'b0);
        step(1'b0, 3'd0, 16'h0,    1'b1, 3'd2, 1'b0);
        check("bp count", 32'(bus.rsp_count),    32'h2);
        check("bp ready", 32'(bus.rd_req_ready), 32'h0);
        step(1'b0, 3'd0, 16'h0,    1'b1, 3'd4, 1'b0);
        check("bp hold count", 32'(bus.rsp_count),   32'h2);
        check("bp head 1111",  32'(bus.rd_rsp_data), 32'h1111);
        step(1'b0, 3'd0, 16'h0,    1'b1, 3'd4, 1'b1);
        check("bp no passthru", 32'(bus.rsp_count),   32'h1);
        check("bp head 2222",   32'(bus.rd_rsp_data), 32'h2222);
        step(1'b0, 3'd0, 16'h0,    1'b1, 3'd4, 1'b1);
        check("bp r4 accepted", 32'(bus.rsp_count),   32'h1);
        check("bp r4 addr",     32'(bus.rd_rsp_addr), 32'h4);
        step(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 1'b1);

        // Snapshot survives a later write; then stream across pointer wrap
        step(1'b1, 3'd6, 16'h00AA, 1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 16'h0,    1'b1, 3'd6, 1'b0);
        step(1'b1, 3'd6, 16'hFFFF, 1'b0, 3'd0, 1'b0);
        check("snapshot data", 32'(bus.rd_rsp_data), 32'h00AA);
        step(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'd0, 16'h0, 1'b1, 3'(i + 1), 1'b1);
            check("stream tag", 32'(bus.rd_rsp_addr), 32'(i + 1));
        end
        step(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 1'b1);

        // Reset between edges with two buffered responses
        step(1'b0, 3'd0, 16'h0,    1'b1, 3'd1, 1'b0);
        step(1'b0, 3'd0, 16'h0,    1'b1, 3'd2, 1'b0);
        check("pre-reset count", 32'(bus.rsp_count), 32'h2);
        @(negedge clk);
        drive_idle();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("mid-reset valid", 32'(bus.rd_rsp_valid), 32'h0);
        check("mid-reset count", 32'(bus.rsp_count),    32'h0);
        check("mid-reset ready", 32'(bus.rd_req_ready), 32'h1);
        step(1'b0, 3'd0, 16'h0,    1'b1, 3'd3, 1'b1);
        check("post-reset r3 valid", 32'(bus.rd_rsp_valid), 32'h1);
        check("post-reset r3 data",  32'(bus.rd_rsp_data),  32'h0);

        // Random traffic
        repeat (500) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) != 0));
        end
        repeat (4) step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
